// File: rtl/pc_pkg.sv
// Shared constants for the fetch-PC generator: default vectors, sequential step
// and the next-PC source encoding used by the priority mux.
package pc_pkg;

    localparam logic [31:0] DEF_RESET_VEC  = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC    = 32'h8000_0180;
    localparam int          DEF_INST_BYTES = 4;

    // Listed in priority order, highest first.
    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_RDR,
        SEL_HOLD,
        SEL_RAS,
        SEL_JMP,
        SEL_SEQ
    } next_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest entry.
// Clear drops the count but keeps the pointer and the entries.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           replace,
    input  logic                           clear,
    input  logic [XLEN-1:0]                wdata,
    output logic [XLEN-1:0]                top,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic [XLEN-1:0] mem [RAS_DEPTH];

    // The pointer width equals log2 of the depth, so these wrap for free.
    assign ptr_inc = ptr + 1'b1;
    assign ptr_dec = ptr - 1'b1;
    assign top     = mem[ptr];

    // NOTE: the entries are reset because the stack is tiny and a known top
    // value simplifies debug. A deep stack should be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else if (push) begin
            ptr          <= ptr_inc;
            mem[ptr_inc] <= wdata;
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + 1'b1;
            end
        end else if (pop && count != '0) begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
        end else if (replace) begin
            mem[ptr] <= wdata;
        end
    end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch-PC register with a prioritised next-PC mux. Returns (jr $ra) are
// predicted from a RAS that each jal pushes.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(DEF_EXC_VEC),
    parameter int              INST_BYTES = DEF_INST_BYTES,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           exc_req,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    input  logic                           id_jump,
    input  logic [XLEN-1:0]                id_jump_pc,
    input  logic                           id_call,
    input  logic [XLEN-1:0]                id_link,
    input  logic                           id_ret,
    output logic [XLEN-1:0]                pc,
    output logic [XLEN-1:0]                pc_plus,
    output logic                           ras_hit,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

    logic            act;
    logic            ras_valid;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] next_pc;
    next_sel_e       sel;

    // Any stall, exception or redirect makes the ID-stage hints stale.
    assign act       = !stall && !exc_req && !redirect_valid;
    assign ras_valid = (ras_count != '0);
    assign ras_hit   = act && id_ret && ras_valid;
    assign pc_plus   = pc + XLEN'(INST_BYTES);

    always_comb begin
        if (exc_req) begin
            sel = SEL_EXC;
        end else if (redirect_valid) begin
            sel = SEL_RDR;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (id_ret && ras_valid) begin
            sel = SEL_RAS;
        end else if (id_jump) begin
            sel = SEL_JMP;
        end else begin
            sel = SEL_SEQ;
        end
    end

    // NOTE: the default assignment before the case keeps this block latch-free.
    always_comb begin
        next_pc = pc_plus;
        case (sel)
            SEL_EXC:  next_pc = EXC_VEC;
            SEL_RDR:  next_pc = redirect_pc;
            SEL_HOLD: next_pc = pc;
            SEL_RAS:  next_pc = ras_top;
            SEL_JMP:  next_pc = id_jump_pc;
            default:  next_pc = pc_plus;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VEC;
        end else begin
            pc <= next_pc;
        end
    end

    // A call and a return in the same cycle replace the top entry in place.
    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (act && id_call && !id_ret),
        .pop     (act && id_ret && !id_call),
        .replace (act && id_call && id_ret),
        .clear   (exc_req),
        .wdata   (id_link),
        .top     (ras_top),
        .count   (ras_count)
    );

endmodule
